dmem_arbiter: RTL
=================

# dmem_arbiter

Sequencing controller and two-requester arbiter for the single-port synchronous data SRAM behind the MEM stage. Grants each cycle's memory slot to either the pipeline load/store path or an external word-access port (loader/debug), generates byte-lane write enables from funct3, formats and sign-extends load data, and stalls the pipeline while a load returns or the external port holds the slot. Sits between the MEM-stage load/store signals and the SRAM macro.

## Interface
- Parameters:
- `ADDR_W`, 12, SRAM word-address width; `mem_addr = addr[ADDR_W+1:2]`, upper address bits ignored.
- `EXT_STARVE_MAX`, 8, consecutive blocked ext cycles before ext wins one slot; 0 = ext always has priority.
- Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: MEM-stage load/store request, held until `cpu_stall` low at an edge.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_funct3` in 3: access size/sign.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data, right-aligned.
- `cpu_stall` out 1: hold MEM stage.
- `cpu_rdata` out 32: formatted load data, 0 when `cpu_rvalid` low.
- `cpu_rvalid` out 1: load data valid this cycle.
- `cpu_misaligned` out 1: combinational, current request misaligned.
- `ext_req` in 1, `ext_we` in 1, `ext_addr` in 32, `ext_wdata` in 32: external word access, held until granted.
- `ext_gnt` out 1: ext access issued this cycle.
- `ext_rdata` out 32, `ext_rvalid` out 1: ext load return, rdata 0 when rvalid low.
- `mem_en` out 1, `mem_we` out 4, `mem_addr` out ADDR_W, `mem_wdata` out 32: SRAM command.
- `mem_rdata` in 32: SRAM read data, valid the cycle after a read command.

## Operation
- States: IDLE, CPU_RD, EXT_RD. Reset: IDLE, starve counter 0, `cpu_rvalid`/`ext_rvalid`/`ext_gnt`/`mem_en` 0, `mem_we` 0, rdata outputs 0, `cpu_stall` 0.
- IDLE grant: ext wins if `ext_req` and counter == `EXT_STARVE_MAX`; else CPU wins if `cpu_req` and aligned; else ext if `ext_req`.
- CPU store granted: `mem_en`=1, lanes per funct3, `cpu_stall`=0, stay IDLE.
- CPU load granted: `mem_en`=1, `mem_we`=0, `cpu_stall`=1, latch funct3 and addr[1:0], go CPU_RD.
- CPU_RD: `cpu_rvalid`=1, `cpu_stall`=0, `cpu_rdata` formatted from `mem_rdata`; no new grant; return IDLE.
- Ext grant: `ext_gnt`=1, `mem_we`=4'hF if `ext_we` else 0; load goes EXT_RD; store stays IDLE. EXT_RD: `ext_rvalid`=1, `ext_rdata`=`mem_rdata`, return IDLE.
- `cpu_stall`=1 whenever `cpu_req` is aligned but not granted (ext won or state not IDLE, except the CPU_RD completion cycle).
- Counter: +1 per cycle `ext_req` high and not granted, saturating at `EXT_STARVE_MAX`; cleared on ext grant or `ext_req` low.
- Store lanes: funct3 000 SB `mem_we`=1<<addr[1:0], byte replicated ×4; 001 SH 4'b0011/4'b1100 by addr[1], half replicated ×2; 010 SW 4'hF.
- Load format: 000 LB sign-ext, 100 LBU zero-ext, selected byte addr[1:0]; 001 LH/101 LHU by addr[1]; 010 and 011/110/111 full word.
- Misaligned: word with addr[1:0]≠0, half with addr[0]=1 → `cpu_misaligned`=1, no SRAM access, `cpu_stall`=0 (trap handled downstream). Ext addresses use addr[ADDR_W+1:2] only, never misaligned.

## Timing
- Store: 0-cycle stall if granted. Load: issue N, data and `cpu_rvalid` N+1; one stall cycle.
- Maximum one SRAM access per two cycles for loads, one per cycle for stores.
- Ext wait worst case `EXT_STARVE_MAX`+2 cycles.
- Reset during CPU_RD/EXT_RD: return abandoned, no rvalid next cycle.

## Configuration
- `DMEM_ARB_EXT_EN` defined: full behaviour above.
- Undefined: ext inputs ignored, `ext_gnt`/`ext_rvalid`/`ext_rdata` tied 0, counter and EXT_RD removed; CPU always granted in IDLE.

## Structure
- Package `dmem_arb_pkg`: state enum, funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), lane-mask width constant.
- Sub-module `dmem_lane_fmt` (combinational): store lane/data generation, alignment check, load extraction/extension.

## Test plan
- SB 0xA5 to addr 0x13 → `mem_we`=4'b1000, `mem_wdata`=0xA5A5A5A5, no stall; then LB 0x13 → stall 1 cycle, `cpu_rdata`=0xFFFFFFA5; LBU → 0x000000A5.
- SH 0x8001 at 0x22, LH 0x22 → `mem_we`=4'b1100, rdata 0xFFFF8001; LW at 0x06 → `cpu_misaligned`=1, `mem_en`=0, `cpu_stall`=0.
- CPU and ext both request, counter 0 → CPU granted, ext waits; back-to-back CPU stores for 8 cycles → cycle 9 `ext_gnt`=1, `cpu_stall`=1, counter cleared.
- Ext load 0x40 while CPU load in CPU_RD → ext granted next cycle, `ext_rvalid` one cycle later with word.
- Reset asserted in CPU_RD → next cycle `cpu_rvalid`=0, state IDLE, all outputs 0.
- `DMEM_ARB_EXT_EN` undefined, `ext_req`=1 constantly → `ext_gnt` never asserts, CPU stores unstalled.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        EXT_RD = 2'd2
    } state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int LANE_W = 4;

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: store lane/data generation, alignment check and load extraction
module dmem_lane_fmt
    import dmem_arb_pkg::*;
(
    input  logic [2:0]        st_funct3,
    input  logic [1:0]        st_off,
    input  logic [31:0]       st_data,
    output logic [LANE_W-1:0] st_lanes,
    output logic [31:0]       st_wdata,
    output logic              misaligned,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_off,
    input  logic [31:0]       ld_raw,
    output logic [31:0]       ld_data
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_b;
    logic        sign_h;

    // store side: byte/half data is replicated so each enabled lane sees its own copy
    always_comb begin
        st_lanes   = '0;
        st_wdata   = st_data;
        misaligned = 1'b0;
        case (st_funct3[1:0])
            SB[1:0]: begin
                st_lanes = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            SH[1:0]: begin
                st_lanes   = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata   = {2{st_data[15:0]}};
                misaligned = st_off[0];
            end
            default: begin
                st_lanes   = 4'hF;
                misaligned = |st_off;
            end
        endcase
    end

    // load side: pick the addressed byte/half and extend unless the unsigned variant
    always_comb begin
        shifted  = ld_raw >> {ld_off, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
        sign_b   = ~ld_funct3[2] & byte_sel[7];
        sign_h   = ~ld_funct3[2] & half_sel[15];
        ld_data  = (ld_funct3[1:0] == LB[1:0]) ? {{24{sign_b}}, byte_sel} :
                   (ld_funct3[1:0] == LH[1:0]) ? {{16{sign_h}}, half_sel} : ld_raw;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data SRAM sequencer, CPU vs external port; ext port enabled by DMEM_ARB_EXT_EN
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int EXT_STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_funct3,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_misaligned,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [31:0]       ext_addr,
    input  logic [31:0]       ext_wdata,
    output logic              ext_gnt,
    output logic [31:0]       ext_rdata,
    output logic              ext_rvalid,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            state;
    state_t            state_nx;
    logic [2:0]        ld_funct3;
    logic [1:0]        ld_off;
    logic [LANE_W-1:0] st_lanes;
    logic [31:0]       st_wdata;
    logic [31:0]       ld_data;
    logic              mis;
    logic              cpu_ok;
    logic              ext_win;
    logic              ext_go;
    logic              ext_done;
    logic              unused_addr;

    dmem_lane_fmt u_fmt (
        .st_funct3 (cpu_funct3),
        .st_off    (cpu_addr[1:0]),
        .st_data   (cpu_wdata),
        .st_lanes  (st_lanes),
        .st_wdata  (st_wdata),
        .misaligned(mis),
        .ld_funct3 (ld_funct3),
        .ld_off    (ld_off),
        .ld_raw    (mem_rdata),
        .ld_data   (ld_data)
    );

    assign cpu_misaligned = cpu_req & mis;
    assign cpu_ok         = cpu_req & ~mis;
    assign unused_addr    = ^cpu_addr[31:ADDR_W+2];

`ifdef DMEM_ARB_EXT_EN
    localparam int CNT_W = $clog2(EXT_STARVE_MAX + 2);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(EXT_STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             unused_ext;

    assign ext_win    = ext_req & ((starve_cnt == STARVE_MAX) | ~cpu_ok);
    assign ext_gnt    = ext_go;
    assign ext_rvalid = ext_done;
    assign ext_rdata  = ext_done ? mem_rdata : '0;
    assign unused_ext = ^{ext_addr[31:ADDR_W+2], ext_addr[1:0]};

    // count consecutive blocked ext cycles; a grant or a dropped request clears it
    always_ff @(posedge clk) begin
        if (reset || !ext_req || ext_go) starve_cnt <= '0;
        else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
    end
`else
    logic unused_ext;

    assign ext_win    = 1'b0;
    assign ext_gnt    = 1'b0;
    assign ext_rvalid = 1'b0;
    assign ext_rdata  = '0;
    assign unused_ext = ^{ext_go, ext_done, ext_req, ext_we, ext_addr, ext_wdata};
`endif

    // state register; load size/offset captured at issue for formatting the return
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ld_funct3 <= '0;
            ld_off    <= '0;
        end else begin
            state <= state_nx;
            if (state_nx == CPU_RD) begin
                ld_funct3 <= cpu_funct3;
                ld_off    <= cpu_addr[1:0];
            end
        end
    end

    // slot grant, SRAM command and pipeline handshake; everything quiet while in reset
    always_comb begin
        state_nx   = state;
        mem_en     = 1'b0;
        mem_we     = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_stall  = 1'b0;
        cpu_rvalid = 1'b0;
        cpu_rdata  = '0;
        ext_go     = 1'b0;
        ext_done   = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (ext_win) begin
                        ext_go    = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = ext_we ? 4'hF : 4'h0;
                        mem_addr  = ext_addr[ADDR_W+1:2];
                        mem_wdata = ext_wdata;
                        cpu_stall = cpu_ok;
                        state_nx  = ext_we ? IDLE : EXT_RD;
                    end else if (cpu_ok) begin
                        mem_en    = 1'b1;
                        mem_we    = cpu_we ? st_lanes : 4'h0;
                        mem_addr  = cpu_addr[ADDR_W+1:2];
                        mem_wdata = cpu_we ? st_wdata : '0;
                        cpu_stall = ~cpu_we;
                        state_nx  = cpu_we ? IDLE : CPU_RD;
                    end
                end
                CPU_RD: begin
                    cpu_rvalid = 1'b1;
                    cpu_rdata  = ld_data;
                    state_nx   = IDLE;
                end
                default: begin
                    ext_done  = 1'b1;
                    cpu_stall = cpu_ok;
                    state_nx  = IDLE;
                end
            endcase
        end
    end

endmodule
